pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch redirects, memory-stall freeze
// and timeout detection, plus saturating stall/redirect performance counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_id_ex,
    input  logic             memread_id_ex,
    input  logic             branch_taken_ex,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pc_sel_redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, REDIRECT = 2'd2} state_e;

    localparam int TW = ($clog2(MEM_TIMEOUT + 1) < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0]    TMO  = TW'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CMAX = '1;

    state_e           state_q;
    logic             pend_q;
    logic [TW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             err_q;
    logic             luh, redirect, lu_stall;

    assign luh = memread_id_ex && (rd_id_ex != 5'd0) &&
                 ((rs1_used_id && rs1_id == rd_id_ex) || (rs2_used_id && rs2_id == rd_id_ex));
    // A pending branch is the frozen EX branch; it fires as soon as memory frees up.
    assign redirect = !mem_busy && (pend_q || branch_taken_ex);
    assign lu_stall = !mem_busy && !redirect && luh && (state_q != REDIRECT);
    assign wait_d   = !mem_busy ? '0 : (wait_q == TMO) ? wait_q : wait_q + 1'b1;

    always_comb begin
        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        id_ex_write     = 1'b1;
        ex_mem_write    = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        pc_sel_redirect = 1'b0;
        if (mem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
        end else if (redirect) begin
            pc_sel_redirect = 1'b1;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
        end else if (lu_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN, MEM_WAIT, REDIRECT:
                    if (mem_busy)      state_q <= MEM_WAIT;
                    else if (redirect) state_q <= REDIRECT;
                    else               state_q <= RUN;
                default:               state_q <= RUN;
            endcase
            if (mem_busy && branch_taken_ex) pend_q <= 1'b1;
            else if (redirect)               pend_q <= 1'b0;
            wait_q <= wait_d;
            if (mem_busy && wait_d == TMO) err_q <= 1'b1;
            if (lu_stall && stall_q != CMAX) stall_q <= stall_q + 1'b1;
            if (redirect && flush_q != CMAX) flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
    assign mem_err   = err_q;
    assign state     = state_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4, CNT_W=2 so timeout and
// counter saturation are reachable in a few cycles.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_id, rs2_id, rd_id_ex;
    logic       rs1_used_id, rs2_used_id, memread_id_ex, branch_taken_ex, mem_busy;
    logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic       if_id_flush, id_ex_flush, pc_sel_redirect, mem_err;
    logic [1:0] stall_cnt, flush_cnt, state;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_id_ex(rd_id_ex), .memread_id_ex(memread_id_ex),
        .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .pc_sel_redirect(pc_sel_redirect), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic clr();
        rs1_id = 5'd0; rs2_id = 5'd0; rd_id_ex = 5'd0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; memread_id_ex = 1'b0;
        branch_taken_ex = 1'b0; mem_busy = 1'b0;
    endtask

    // load in ID/EX writing x5, ID reads x5 on rs2
    task automatic set_luh(input logic [4:0] rd);
        memread_id_ex = 1'b1; rd_id_ex = rd; rs2_id = 5'd5; rs2_used_id = 1'b1;
        rs1_id = 5'd7; rs1_used_id = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // settle point for combinational outputs after a drive
    task automatic settle();
        #3;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        #12;
        chk("rst_state", state, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_flush", flush_cnt, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_pcw", pc_write, 1);
        chk("rst_exmw", ex_mem_write, 1);
        rst_n = 1'b1;
        cyc();

        // load-use bubble
        set_luh(5'd5); settle();
        chk("lu_pcw", pc_write, 0);
        chk("lu_ifidw", if_id_write, 0);
        chk("lu_idexfl", id_ex_flush, 1);
        chk("lu_exmw", ex_mem_write, 1);
        chk("lu_ifidfl", if_id_flush, 0);
        cyc(); clr(); settle();
        chk("lu_stallcnt", stall_cnt, 1);
        chk("lu_once_pcw", pc_write, 1);
        chk("lu_once_fl", id_ex_flush, 0);

        // rd = x0 never stalls
        set_luh(5'd0); rs2_id = 5'd0; settle();
        chk("rd0_pcw", pc_write, 1);
        chk("rd0_fl", id_ex_flush, 0);
        cyc(); clr(); settle();
        chk("rd0_stallcnt", stall_cnt, 1);

        // branch during mem stall: held 3 cycles then released
        branch_taken_ex = 1'b1; mem_busy = 1'b1; settle();
        chk("mb_pcw", pc_write, 0);
        chk("mb_idexw", id_ex_write, 0);
        chk("mb_exmw", ex_mem_write, 0);
        chk("mb_sel", pc_sel_redirect, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(); settle();
            chk("mb_state", state, 1);
            chk("mb_ifidw", if_id_write, 0);
        end
        mem_busy = 1'b0; settle();
        chk("mbr_sel", pc_sel_redirect, 1);
        chk("mbr_ifidfl", if_id_flush, 1);
        chk("mbr_idexfl", id_ex_flush, 1);
        chk("mbr_pcw", pc_write, 1);
        chk("mbr_state", state, 1);
        cyc(); branch_taken_ex = 1'b0; settle();
        chk("mbr_state2", state, 2);
        chk("mbr_flushcnt", flush_cnt, 1);
        chk("mbr_sel_once", pc_sel_redirect, 0);
        chk("mbr_err", mem_err, 0);
        cyc(); settle();
        chk("mbr_state_run", state, 0);

        // branch and load-use together: redirect wins, luh ignored in REDIRECT
        branch_taken_ex = 1'b1; set_luh(5'd5); settle();
        chk("bl_sel", pc_sel_redirect, 1);
        chk("bl_pcw", pc_write, 1);
        chk("bl_ifidw", if_id_write, 1);
        chk("bl_ifidfl", if_id_flush, 1);
        cyc(); branch_taken_ex = 1'b0; settle();
        chk("bl_state", state, 2);
        chk("bl_stallcnt", stall_cnt, 1);
        chk("bl_flushcnt", flush_cnt, 2);
        chk("redir_luh_pcw", pc_write, 1);
        chk("redir_luh_fl", id_ex_flush, 0);
        cyc(); clr(); settle();
        chk("bl_state_run", state, 0);
        chk("redir_luh_cnt", stall_cnt, 1);

        // memory timeout at 4 consecutive busy cycles, sticky
        mem_busy = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc(); settle();
            chk("tmo_err", mem_err, (k >= 4) ? 1 : 0);
        end
        mem_busy = 1'b0;
        cyc(); settle();
        chk("tmo_sticky", mem_err, 1);
        chk("tmo_state", state, 0);

        // counter saturation at 2'b11
        for (int k = 0; k < 5; k++) begin
            set_luh(5'd5); cyc(); clr(); cyc();
        end
        settle();
        chk("sat_stall", stall_cnt, 3);
        for (int k = 0; k < 2; k++) begin
            branch_taken_ex = 1'b1; cyc(); clr(); cyc();
        end
        settle();
        chk("sat_flush", flush_cnt, 3);
        chk("sat_err", mem_err, 1);

        // async reset mid-MEM_WAIT with a pending branch
        branch_taken_ex = 1'b1; mem_busy = 1'b1;
        cyc(); settle();
        chk("pre_rst_state", state, 1);
        rst_n = 1'b0; #1;
        chk("arst_state", state, 0);
        chk("arst_stall", stall_cnt, 0);
        chk("arst_flush", flush_cnt, 0);
        chk("arst_err", mem_err, 0);
        chk("arst_pcw", pc_write, 0);
        clr(); #1;
        chk("arst_nopend", pc_sel_redirect, 0);
        chk("arst_pcw_run", pc_write, 1);
        cyc();
        rst_n = 1'b1;
        cyc(); settle();
        chk("post_rst_state", state, 0);
        chk("post_rst_flush", flush_cnt, 0);
        chk("post_rst_sel", pc_sel_redirect, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule
